// File: rtl/riscv_compressor_gpr.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_compressor_gpr
//  Description : Two-stage RV32 -> RVC instruction compressor. Stage 1 captures
//                the base instruction together with a one-hot compressed-form
//                classification. Stage 2 assembles the 16-bit encoding or
//                selects passthrough. Valid/ready on both sides. Statistics
//                counters track delivered and compressed instructions.
//  Revision    : 1.0  initial release
// ============================================================================
module riscv_compressor_gpr #(
    parameter int RegAddrWidth = 5,
    parameter int CntWidth     = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_instr,
    output logic                out_compressed,
    input  logic                stat_clr,
    output logic [CntWidth-1:0] stat_total,
    output logic [CntWidth-1:0] stat_comp
);

    // ------------------------------------------------------------------------
    // Compressed-form indices, in priority order (lowest index wins)
    // ------------------------------------------------------------------------
    localparam int c_F_EBREAK  = 0;
    localparam int c_F_NOP     = 1;
    localparam int c_F_ADDI    = 2;
    localparam int c_F_LI      = 3;
    localparam int c_F_MV      = 4;
    localparam int c_F_ADD     = 5;
    localparam int c_F_SUB     = 6;
    localparam int c_F_XOR     = 7;
    localparam int c_F_OR      = 8;
    localparam int c_F_AND     = 9;
    localparam int c_F_LW      = 10;
    localparam int c_F_SW      = 11;
    localparam int c_F_LWSP    = 12;
    localparam int c_F_SWSP    = 13;
    localparam int c_F_J       = 14;
    localparam int c_F_JAL     = 15;
    localparam int c_F_JR      = 16;
    localparam int c_F_JALR    = 17;
    localparam int c_NUM_FORMS = 18;

    localparam logic [6:0]  c_OP_IMM    = 7'b0010011;
    localparam logic [6:0]  c_OP_REG    = 7'b0110011;
    localparam logic [6:0]  c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  c_OP_STORE  = 7'b0100011;
    localparam logic [6:0]  c_OP_JAL    = 7'b1101111;
    localparam logic [6:0]  c_OP_JALR   = 7'b1100111;
    localparam logic [31:0] c_EBREAK    = 32'h0010_0073;
    localparam logic [6:0]  c_F7_ZERO   = 7'b0000000;
    localparam logic [6:0]  c_F7_SUB    = 7'b0100000;

    localparam logic [RegAddrWidth-1:0] c_X0 = RegAddrWidth'(0);
    localparam logic [RegAddrWidth-1:0] c_X1 = RegAddrWidth'(1);
    localparam logic [RegAddrWidth-1:0] c_X2 = RegAddrWidth'(2);

    // Register lies in the x8..x15 window addressable by 3-bit RVC fields
    function automatic logic is_prime(input logic [RegAddrWidth-1:0] r);
        return (r >= RegAddrWidth'(8)) && (r <= RegAddrWidth'(15));
    endfunction

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    logic w_s1_adv;
    logic w_s2_adv;
    logic w_out_fire;

    logic                   s1_valid_q;
    logic [31:0]            s1_instr_q;
    logic [c_NUM_FORMS-1:0] s1_form_q;
    logic [11:0]            s1_imm_q;

    logic        out_valid_q;
    logic [31:0] out_instr_q;
    logic        out_compressed_q;
    logic [31:0] out_instr_d;
    logic        out_compressed_d;

    logic [CntWidth-1:0] stat_total_q;
    logic [CntWidth-1:0] stat_comp_q;

    assign w_s2_adv   = !out_valid_q || out_ready;
    assign w_s1_adv   = !s1_valid_q || w_s2_adv;
    assign w_out_fire = out_valid_q && out_ready;

    assign in_ready       = w_s1_adv;
    assign out_valid      = out_valid_q;
    assign out_instr      = out_instr_q;
    assign out_compressed = out_compressed_q;
    assign stat_total     = stat_total_q;
    assign stat_comp      = stat_comp_q;

    // ------------------------------------------------------------------------
    // Stage 1 classification (combinational on in_instr)
    // ------------------------------------------------------------------------
    logic [6:0]              w_opcode;
    logic [2:0]              w_funct3;
    logic [6:0]              w_funct7;
    logic [RegAddrWidth-1:0] w_rd;
    logic [RegAddrWidth-1:0] w_rs1;
    logic [RegAddrWidth-1:0] w_rs2;
    logic signed [11:0]      w_imm_i;
    logic signed [11:0]      w_imm_s;
    logic signed [20:0]      w_imm_j;

    assign w_opcode = in_instr[6:0];
    assign w_funct3 = in_instr[14:12];
    assign w_funct7 = in_instr[31:25];
    assign w_rd     = in_instr[7  +: RegAddrWidth];
    assign w_rs1    = in_instr[15 +: RegAddrWidth];
    assign w_rs2    = in_instr[20 +: RegAddrWidth];
    assign w_imm_i  = in_instr[31:20];
    assign w_imm_s  = {in_instr[31:25], in_instr[11:7]};
    assign w_imm_j  = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    logic w_is_addi, w_is_add, w_is_sub, w_is_xor, w_is_or, w_is_and;
    logic w_is_lw, w_is_sw, w_is_jal, w_is_jalr;

    assign w_is_addi = (w_opcode == c_OP_IMM)   && (w_funct3 == 3'b000);
    assign w_is_add  = (w_opcode == c_OP_REG)   && (w_funct3 == 3'b000) && (w_funct7 == c_F7_ZERO);
    assign w_is_sub  = (w_opcode == c_OP_REG)   && (w_funct3 == 3'b000) && (w_funct7 == c_F7_SUB);
    assign w_is_xor  = (w_opcode == c_OP_REG)   && (w_funct3 == 3'b100) && (w_funct7 == c_F7_ZERO);
    assign w_is_or   = (w_opcode == c_OP_REG)   && (w_funct3 == 3'b110) && (w_funct7 == c_F7_ZERO);
    assign w_is_and  = (w_opcode == c_OP_REG)   && (w_funct3 == 3'b111) && (w_funct7 == c_F7_ZERO);
    assign w_is_lw   = (w_opcode == c_OP_LOAD)  && (w_funct3 == 3'b010);
    assign w_is_sw   = (w_opcode == c_OP_STORE) && (w_funct3 == 3'b010);
    assign w_is_jal  = (w_opcode == c_OP_JAL);
    assign w_is_jalr = (w_opcode == c_OP_JALR)  && (w_funct3 == 3'b000);

    // Inclusive immediate windows of each compressed form
    logic w_imm6_ok, w_lw_off_ok, w_sw_off_ok, w_lwsp_off_ok, w_swsp_off_ok, w_j_ok;
    logic w_alu_regs_ok;

    assign w_imm6_ok     = (w_imm_i >= -12'sd32) && (w_imm_i <= 12'sd31);
    assign w_lw_off_ok   = (w_imm_i >= 12'sd0) && (w_imm_i <= 12'sd124) && (w_imm_i[1:0] == 2'b00);
    assign w_sw_off_ok   = (w_imm_s >= 12'sd0) && (w_imm_s <= 12'sd124) && (w_imm_s[1:0] == 2'b00);
    assign w_lwsp_off_ok = (w_imm_i >= 12'sd0) && (w_imm_i <= 12'sd252) && (w_imm_i[1:0] == 2'b00);
    assign w_swsp_off_ok = (w_imm_s >= 12'sd0) && (w_imm_s <= 12'sd252) && (w_imm_s[1:0] == 2'b00);
    assign w_j_ok        = (w_imm_j >= -21'sd2048) && (w_imm_j <= 21'sd2046);
    assign w_alu_regs_ok = (w_rd == w_rs1) && is_prime(w_rd) && is_prime(w_rs2);

    logic [c_NUM_FORMS-1:0] w_raw;
    logic [c_NUM_FORMS-1:0] w_form;
    logic [11:0]            w_imm_sel;

    // Raw per-form matches; several may overlap in principle, priority resolves them
    always_comb begin
        w_raw = '0;
        w_raw[c_F_EBREAK] = (in_instr == c_EBREAK);
        w_raw[c_F_NOP]    = w_is_addi && (w_rd == c_X0) && (w_rs1 == c_X0) && (w_imm_i == 12'sd0);
        w_raw[c_F_ADDI]   = w_is_addi && (w_rd == w_rs1) && (w_rd != c_X0) && (w_imm_i != 12'sd0) && w_imm6_ok;
        w_raw[c_F_LI]     = w_is_addi && (w_rd != c_X0) && (w_rs1 == c_X0) && w_imm6_ok;
        w_raw[c_F_MV]     = w_is_add && (w_rd != c_X0) && (w_rs1 == c_X0) && (w_rs2 != c_X0);
        w_raw[c_F_ADD]    = w_is_add && (w_rd == w_rs1) && (w_rd != c_X0) && (w_rs2 != c_X0);
        w_raw[c_F_SUB]    = w_is_sub && w_alu_regs_ok;
        w_raw[c_F_XOR]    = w_is_xor && w_alu_regs_ok;
        w_raw[c_F_OR]     = w_is_or  && w_alu_regs_ok;
        w_raw[c_F_AND]    = w_is_and && w_alu_regs_ok;
        w_raw[c_F_LW]     = w_is_lw && is_prime(w_rd) && is_prime(w_rs1) && w_lw_off_ok;
        w_raw[c_F_SW]     = w_is_sw && is_prime(w_rs1) && is_prime(w_rs2) && w_sw_off_ok;
        w_raw[c_F_LWSP]   = w_is_lw && (w_rs1 == c_X2) && (w_rd != c_X0) && w_lwsp_off_ok;
        w_raw[c_F_SWSP]   = w_is_sw && (w_rs1 == c_X2) && w_swsp_off_ok;
        w_raw[c_F_J]      = w_is_jal && (w_rd == c_X0) && w_j_ok;
        w_raw[c_F_JAL]    = w_is_jal && (w_rd == c_X1) && w_j_ok;
        w_raw[c_F_JR]     = w_is_jalr && (w_imm_i == 12'sd0) && (w_rs1 != c_X0) && (w_rd == c_X0);
        w_raw[c_F_JALR]   = w_is_jalr && (w_imm_i == 12'sd0) && (w_rs1 != c_X0) && (w_rd == c_X1);
    end

    // Keep only the lowest-index (highest-priority) match
    assign w_form = w_raw & (-w_raw);

    // One immediate field carried forward: S-type for stores, J-type low bits for JAL, else I-type
    always_comb begin
        w_imm_sel = in_instr[31:20];
        if (w_opcode == c_OP_STORE) begin
            w_imm_sel = w_imm_s;
        end else if (w_opcode == c_OP_JAL) begin
            w_imm_sel = w_imm_j[11:0];
        end
    end

    // Stage 1 register: capture instruction and classification when the stage advances
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_instr_q <= '0;
            s1_form_q  <= '0;
            s1_imm_q   <= '0;
        end else if (w_s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_instr_q <= in_instr;
                s1_form_q  <= w_form;
                s1_imm_q   <= w_imm_sel;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2 assembly
    // ------------------------------------------------------------------------
    logic [RegAddrWidth-1:0] s2_rd;
    logic [RegAddrWidth-1:0] s2_rs1;
    logic [RegAddrWidth-1:0] s2_rs2;
    logic [11:0]             s2_imm;
    logic [15:0]             w_rvc;

    assign s2_rd  = s1_instr_q[7  +: RegAddrWidth];
    assign s2_rs1 = s1_instr_q[15 +: RegAddrWidth];
    assign s2_rs2 = s1_instr_q[20 +: RegAddrWidth];
    assign s2_imm = s1_imm_q;

    // Build the 16-bit RVC word for the selected form
    always_comb begin
        w_rvc = 16'h0000;
        if (s1_form_q[c_F_EBREAK]) begin
            w_rvc = 16'h9002;
        end else if (s1_form_q[c_F_NOP]) begin
            w_rvc = 16'h0001;
        end else if (s1_form_q[c_F_ADDI]) begin
            w_rvc = {3'b000, s2_imm[5], s2_rd, s2_imm[4:0], 2'b01};
        end else if (s1_form_q[c_F_LI]) begin
            w_rvc = {3'b010, s2_imm[5], s2_rd, s2_imm[4:0], 2'b01};
        end else if (s1_form_q[c_F_MV]) begin
            w_rvc = {4'b1000, s2_rd, s2_rs2, 2'b10};
        end else if (s1_form_q[c_F_ADD]) begin
            w_rvc = {4'b1001, s2_rd, s2_rs2, 2'b10};
        end else if (s1_form_q[c_F_SUB]) begin
            w_rvc = {6'b100011, s2_rd[2:0], 2'b00, s2_rs2[2:0], 2'b01};
        end else if (s1_form_q[c_F_XOR]) begin
            w_rvc = {6'b100011, s2_rd[2:0], 2'b01, s2_rs2[2:0], 2'b01};
        end else if (s1_form_q[c_F_OR]) begin
            w_rvc = {6'b100011, s2_rd[2:0], 2'b10, s2_rs2[2:0], 2'b01};
        end else if (s1_form_q[c_F_AND]) begin
            w_rvc = {6'b100011, s2_rd[2:0], 2'b11, s2_rs2[2:0], 2'b01};
        end else if (s1_form_q[c_F_LW]) begin
            w_rvc = {3'b010, s2_imm[5:3], s2_rs1[2:0], s2_imm[2], s2_imm[6], s2_rd[2:0], 2'b00};
        end else if (s1_form_q[c_F_SW]) begin
            w_rvc = {3'b110, s2_imm[5:3], s2_rs1[2:0], s2_imm[2], s2_imm[6], s2_rs2[2:0], 2'b00};
        end else if (s1_form_q[c_F_LWSP]) begin
            w_rvc = {3'b010, s2_imm[5], s2_rd, s2_imm[4:2], s2_imm[7:6], 2'b10};
        end else if (s1_form_q[c_F_SWSP]) begin
            w_rvc = {3'b110, s2_imm[5:2], s2_imm[7:6], s2_rs2, 2'b10};
        end else if (s1_form_q[c_F_J]) begin
            w_rvc = {3'b101, s2_imm[11], s2_imm[4], s2_imm[9:8], s2_imm[10],
                     s2_imm[6], s2_imm[7], s2_imm[3:1], s2_imm[5], 2'b01};
        end else if (s1_form_q[c_F_JAL]) begin
            w_rvc = {3'b001, s2_imm[11], s2_imm[4], s2_imm[9:8], s2_imm[10],
                     s2_imm[6], s2_imm[7], s2_imm[3:1], s2_imm[5], 2'b01};
        end else if (s1_form_q[c_F_JR]) begin
            w_rvc = {4'b1000, s2_rs1, 5'b00000, 2'b10};
        end else if (s1_form_q[c_F_JALR]) begin
            w_rvc = {4'b1001, s2_rs1, 5'b00000, 2'b10};
        end
    end

    assign out_compressed_d = |s1_form_q;
    assign out_instr_d      = out_compressed_d ? {16'h0000, w_rvc} : s1_instr_q;

    // Output register: loads only when downstream can take it, so data holds during stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q      <= 1'b0;
            out_instr_q      <= '0;
            out_compressed_q <= 1'b0;
        end else if (w_s2_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_instr_q      <= out_instr_d;
                out_compressed_q <= out_compressed_d;
            end
        end
    end

    // Statistics: clear wins over a same-cycle delivery; counters wrap naturally
    always_ff @(posedge clk) begin
        if (!rst_n || stat_clr) begin
            stat_total_q <= '0;
            stat_comp_q  <= '0;
        end else if (w_out_fire) begin
            stat_total_q <= stat_total_q + CntWidth'(1);
            stat_comp_q  <= stat_comp_q + CntWidth'(out_compressed_q);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_compressor_gpr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riscv_compressor_gpr
//  Description : Directed self-checking bench for riscv_compressor_gpr.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_riscv_compressor_gpr;

    localparam int CNT_W  = 32;
    localparam int N_VEC  = 25;
    localparam int N_STRM = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             out_compressed;
    logic             stat_clr;
    logic [CNT_W-1:0] stat_total;
    logic [CNT_W-1:0] stat_comp;

    int n_checks = 0;
    int n_fail   = 0;

    riscv_compressor_gpr #(
        .RegAddrWidth (5),
        .CntWidth     (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instr       (in_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_compressed (out_compressed),
        .stat_clr       (stat_clr),
        .stat_total     (stat_total),
        .stat_comp      (stat_comp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One instruction through an idle pipeline with out_ready high
    task automatic send_vec(input string tag, input logic [31:0] instr,
                            input logic [31:0] exp, input logic expc);
        in_valid = 1'b1;
        in_instr = instr;
        tick();
        in_valid = 1'b0;
        in_instr = 32'h0;
        check({tag, "_lat1"}, {31'b0, out_valid}, 32'd0);
        tick();
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_instr"}, out_instr, exp);
        check({tag, "_comp"}, {31'b0, out_compressed}, {31'b0, expc});
        tick();
    endtask

    logic [31:0] v_in  [N_VEC];
    logic [31:0] v_exp [N_VEC];
    logic        v_c   [N_VEC];
    logic [31:0] s_in  [N_STRM];
    logic [31:0] s_exp [N_STRM];
    logic        s_c   [N_STRM];

    initial begin
        int          sent;
        int          recv;
        int          cyc;
        int          inflight;
        logic        stall_prev;
        logic [31:0] held;
        logic        held_c;

        v_in  = '{32'h00540413, 32'h00000013, 32'h00B50533, 32'h00852483, 32'h00100073,
                  32'h003100B3, 32'h02040413, 32'h01F40413, 32'hFE040413, 32'h07C52483,
                  32'h08052483, 32'hFFC52483, 32'hFFF00293, 32'h006002B3, 32'h40940433,
                  32'h0087F7B3, 32'h00952223, 32'h0FC12083, 32'h10012083, 32'h00112423,
                  32'h801FF06F, 32'h001000EF, 32'h7FE000EF, 32'h00008067, 32'h00000012};
        v_exp = '{32'h00000415, 32'h00000001, 32'h0000952E, 32'h00004504, 32'h00009002,
                  32'h003100B3, 32'h02040413, 32'h0000047D, 32'h00001401, 32'h00005D64,
                  32'h08052483, 32'hFFC52483, 32'h000052FD, 32'h0000829A, 32'h00008C05,
                  32'h00008FE1, 32'h0000C144, 32'h000050FE, 32'h10012083, 32'h0000C406,
                  32'h0000B001, 32'h001000EF, 32'h00002FFD, 32'h00008082, 32'h00000012};
        v_c   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                  1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                  1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                  1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                  1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        s_in  = '{32'h00540413, 32'h003100B3, 32'h00B50533, 32'h02040413,
                  32'h00852483, 32'h00100073, 32'h08052483, 32'h00008067};
        s_exp = '{32'h00000415, 32'h003100B3, 32'h0000952E, 32'h02040413,
                  32'h00004504, 32'h00009002, 32'h08052483, 32'h00008082};
        s_c   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        out_ready = 1'b1;
        stat_clr  = 1'b0;
        repeat (3) tick();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_comp", {31'b0, out_compressed}, 32'd0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_total", stat_total, 32'd0);
        check("rst_comp", stat_comp, 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("post_rst_out_valid", {31'b0, out_valid}, 32'd0);

        // Directed vector table, one instruction at a time
        for (int i = 0; i < N_VEC; i++) begin
            send_vec($sformatf("vec%0d", i), v_in[i], v_exp[i], v_c[i]);
        end
        check("table_total", stat_total, 32'd25);
        check("table_comp", stat_comp, 32'd18);

        // Plain clear
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        check("clr_total", stat_total, 32'd0);
        check("clr_comp", stat_comp, 32'd0);

        // Back-to-back stream with out_ready pattern 1,0,0,1,...
        sent       = 0;
        recv       = 0;
        cyc        = 0;
        stall_prev = 1'b0;
        held       = 32'h0;
        held_c     = 1'b0;
        while (recv < N_STRM && cyc < 200) begin
            in_valid  = (sent < N_STRM);
            in_instr  = (sent < N_STRM) ? s_in[sent] : 32'h0;
            out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            #4;
            inflight = sent - recv;
            check("strm_in_ready", {31'b0, in_ready},
                  {31'b0, !((inflight == 2) && !out_ready)});
            if (stall_prev) begin
                check("strm_hold_valid", {31'b0, out_valid}, 32'd1);
                check("strm_hold_instr", out_instr, held);
                check("strm_hold_comp", {31'b0, out_compressed}, {31'b0, held_c});
            end
            if (out_valid && out_ready) begin
                check($sformatf("strm_instr%0d", recv), out_instr, s_exp[recv]);
                check($sformatf("strm_comp%0d", recv), {31'b0, out_compressed}, {31'b0, s_c[recv]});
                recv++;
            end
            stall_prev = out_valid && !out_ready;
            held       = out_instr;
            held_c     = out_compressed;
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        check("strm_delivered", recv, N_STRM);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("strm_total", stat_total, 32'd8);
        check("strm_comp_cnt", stat_comp, 32'd5);

        // Clear in the same cycle as an output handshake
        in_valid = 1'b1;
        in_instr = 32'h00540413;
        tick();
        in_valid = 1'b0;
        tick();
        check("clrhs_out_valid", {31'b0, out_valid}, 32'd1);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        check("clrhs_total", stat_total, 32'd0);
        check("clrhs_comp", stat_comp, 32'd0);
        check("clrhs_drained", {31'b0, out_valid}, 32'd0);
        send_vec("cnt_one", 32'h00540413, 32'h00000415, 1'b1);
        check("cnt_one_total", stat_total, 32'd1);
        check("cnt_one_comp", stat_comp, 32'd1);

        // Fill both stages under backpressure, then reset
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00B50533;
        tick();
        in_instr  = 32'h00852483;
        tick();
        in_valid  = 1'b0;
        check("full_out_valid", {31'b0, out_valid}, 32'd1);
        check("full_out_instr", out_instr, 32'h0000952E);
        check("full_in_ready", {31'b0, in_ready}, 32'd0);
        rst_n = 1'b0;
        tick();
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_out_instr", out_instr, 32'h0);
        check("midrst_total", stat_total, 32'd0);
        check("midrst_comp", stat_comp, 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        check("midrst_idle1", {31'b0, out_valid}, 32'd0);
        tick();
        check("midrst_idle2", {31'b0, out_valid}, 32'd0);
        send_vec("post_midrst", 32'h00100073, 32'h00009002, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
